// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, constants and GF(2^8) helpers.
package aes_pkg;
   typedef logic [0:127] block_t;
   typedef logic [3:0]   rk_idx_t;

   localparam int      NR_AES128 = 10;
   localparam rk_idx_t RK_FIRST  = 4'd10;
   localparam rk_idx_t RK_LAST   = 4'd0;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} inv_ctrl_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Undo the affine map, then invert in GF(2^8) as x^254 (zero maps to zero).
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] a;
      logic [7:0] r;
      a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         a = gmul(a, a);
         r = gmul(r, a);
      end
      return r;
   endfunction
endpackage

// File: rtl/InvRoundBlock.sv
// One full inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module InvRoundBlock
   import aes_pkg::*;
(
   input  block_t in_state,
   input  block_t round_key,
   output block_t out_state
);
   block_t isr_out, isb_out, ark_out;

   inv_shift_rows  u_isr (.din(in_state), .dout(isr_out));
   inv_sub_bytes   u_isb (.din(isr_out),  .dout(isb_out));
   add_round_key   u_ark (.din(isb_out),  .rk(round_key), .dout(ark_out));
   inv_mix_columns u_imc (.din(ark_out),  .dout(out_state));
endmodule

// File: rtl/add_round_key.sv
// AddRoundKey: XOR of the state with a 128-bit round key.
module add_round_key
   import aes_pkg::*;
(
   input  block_t din,
   input  block_t rk,
   output block_t dout
);
   assign dout = din ^ rk;
endmodule

// File: rtl/inv_final_round.sv
// Last inverse round: InvShiftRows, InvSubBytes, AddRoundKey; no InvMixColumns.
module inv_final_round
   import aes_pkg::*;
(
   input  block_t in_state,
   input  block_t round_key,
   output block_t out_state
);
   block_t isr_out, isb_out;

   inv_shift_rows u_isr (.din(in_state), .dout(isr_out));
   inv_sub_bytes  u_isb (.din(isr_out),  .dout(isb_out));
   add_round_key  u_ark (.din(isb_out),  .rk(round_key), .dout(out_state));
endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns: each column multiplied by the {0e,0b,0d,09} circulant matrix.
module inv_mix_columns
   import aes_pkg::*;
(
   input  block_t din,
   output block_t dout
);
   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = din[32*gi      +: 8];
      assign a1 = din[32*gi + 8  +: 8];
      assign a2 = din[32*gi + 16 +: 8];
      assign a3 = din[32*gi + 24 +: 8];
      assign dout[32*gi      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      assign dout[32*gi + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      assign dout[32*gi + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      assign dout[32*gi + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
   end
endmodule

// File: rtl/inv_shift_rows.sv
// InvShiftRows: row r of the column-major state rotates right by r bytes.
module inv_shift_rows
   import aes_pkg::*;
(
   input  block_t din,
   output block_t dout
);
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      assign dout[8*gi +: 8] = din[8*((((gi/4) + 4 - (gi%4)) % 4)*4 + (gi%4)) +: 8];
   end
endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: inverse S-box applied to every byte of the state.
module inv_sub_bytes
   import aes_pkg::*;
(
   input  block_t din,
   output block_t dout
);
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      assign dout[8*gi +: 8] = inv_sbox(din[8*gi +: 8]);
   end
endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: rounds 9..1 through one InvRoundBlock.
// Optional block counter output blk_cnt is enabled by defining INV_CIPHER_BLKCNT_EN.
module inv_cipher_ctrl
   import aes_pkg::*;
#(
   parameter int NR = NR_AES128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  block_t       in_data,
   output rk_idx_t      rk_idx,
   input  block_t       rk_data,
   input  logic         key_valid,
   output logic         out_valid,
   input  logic         out_ready,
   output block_t       out_data
`ifdef INV_CIPHER_BLKCNT_EN
   ,
   output logic [31:0]  blk_cnt
`endif
);
   localparam logic [3:0] RND_FIRST = 4'(NR - 1);

   inv_ctrl_state_e fsm_reg;
   block_t          data_reg;
   logic [3:0]      rnd_reg;
   block_t          round_out;
   block_t          final_out;
   logic            accept;

   assign in_ready  = (fsm_reg == IDLE) && key_valid;
   assign out_valid = (fsm_reg == DONE);
   assign accept    = in_valid && in_ready;

   // Key index is a pure decode of registered state so the key store sees a stable address.
   always_comb begin
      rk_idx = RK_FIRST;
      case (fsm_reg)
         ROUND:   rk_idx = rnd_reg;
         FINAL:   rk_idx = RK_LAST;
         default: rk_idx = RK_FIRST;
      endcase
   end

   InvRoundBlock u_round (
      .in_state  (data_reg),
      .round_key (rk_data),
      .out_state (round_out)
   );

   inv_final_round u_final (
      .in_state  (data_reg),
      .round_key (rk_data),
      .out_state (final_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg  <= IDLE;
         data_reg <= '0;
         rnd_reg  <= RND_FIRST;
         out_data <= '0;
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (accept) begin
                  data_reg <= in_data ^ rk_data;
                  rnd_reg  <= RND_FIRST;
                  fsm_reg  <= ROUND;
               end
            end
            ROUND: begin
               // A missing key schedule freezes everything until it returns.
               if (key_valid) begin
                  data_reg <= round_out;
                  if (rnd_reg == 4'd1) begin
                     rnd_reg <= RND_FIRST;
                     fsm_reg <= FINAL;
                  end else begin
                     rnd_reg <= rnd_reg - 4'd1;
                  end
               end
            end
            FINAL: begin
               if (key_valid) begin
                  out_data <= final_out;
                  fsm_reg  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) fsm_reg <= IDLE;
            end
            default: fsm_reg <= IDLE;
         endcase
      end
   end

`ifdef INV_CIPHER_BLKCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt <= 32'd0;
      end else if (out_valid && out_ready) begin
         blk_cnt <= blk_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Self-checking bench for inv_cipher_ctrl against a table-driven AES-128 decryption model.
module tb_inv_cipher_ctrl;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         key_valid;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
`ifdef INV_CIPHER_BLKCNT_EN
   logic [31:0]  blk_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [7:0]   exp_t [255];
   int           log_t [256];
   logic [127:0] rk_mem [16];
   int           rk_seq [$];

   inv_cipher_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk_data   (rk_data),
      .key_valid (key_valid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef INV_CIPHER_BLKCNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
   );

   assign rk_data = rk_mem[rk_idx];

   always #5 clk = ~clk;

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_t[(log_t[a] + log_t[b]) % 255];
   endfunction

   // Walk the powers of 3 (and of 1/3) to build log/exp tables and the S-box.
   task automatic build_tables();
      logic [7:0] p, q, x;
      int i;
      p = 8'h01; q = 8'h01; i = 0;
      exp_t[0] = 8'h01; log_t[1] = 0;
      forever begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         i++;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox[p] = x ^ 8'h63;
         if (p == 8'h01) break;
         exp_t[i] = p;
         log_t[p] = i;
      end
      sbox[0] = 8'h63;
      for (int k = 0; k < 256; k++) isbox[sbox[k]] = 8'(k);
   endtask

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk_mem[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   // Textbook decryption on a 4x4 byte matrix, state[row][col] = byte 4*col+row.
   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] kr, res;
      kr = rk_mem[10];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = ct[127-8*(4*c+r) -: 8] ^ kr[127-8*(4*c+r) -: 8];
      for (int rd = 9; rd >= 0; rd--) begin
         kr = rk_mem[rd];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = s[r][(c + 4 - r) % 4];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] = isbox[t[r][c]] ^ kr[127-8*(4*c+r) -: 8];
         if (rd > 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
               s[0][c] = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
               s[1][c] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
               s[2][c] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
               s[3][c] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
            end
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   // Presents one block, waits for out_valid (bounded); optional 3-cycle key drop at round 5.
   task automatic drive_block(input logic [127:0] ct, input bit do_stall,
                              output logic [127:0] pt, output int lat, output bit tmo);
      int n, stalls;
      tmo = 0; pt = 'x; lat = 0; stalls = 0;
      rk_seq.delete();
      @(negedge clk);
      in_data = ct; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) begin in_valid = 1'b0; tmo = 1; return; end
      rk_seq.push_back(int'(rk_idx));
      forever begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         lat++;
         if (out_valid) break;
         if (lat >= 60) begin tmo = 1; break; end
         if (do_stall && rk_idx == 4'd5 && stalls < 3) begin
            key_valid = 1'b0; stalls++;
         end else begin
            key_valid = 1'b1; rk_seq.push_back(int'(rk_idx));
         end
      end
      key_valid = 1'b1;
      if (!tmo) pt = out_data;
      $display("block ct=%h pt=%h latency=%0d", ct, pt, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL reset_rk_idx got %0d want 10", rk_idx); end
      rst_n = 1'b1; key_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
      checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL idle_rk_idx got %0d want 10", rk_idx); end
   endtask

   task automatic test_fips();
      logic [127:0] pt; int lat; bit tmo, bad;
      load_key(FIPS_KEY);
      drive_block(FIPS_CT, 1'b0, pt, lat, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL fips_timeout got timeout want out_valid"); end
      checks++; if (pt !== FIPS_PT) begin errors++; $display("FAIL fips_data got %h want %h", pt, FIPS_PT); end
      checks++; if (lat != 11) begin errors++; $display("FAIL fips_latency got %0d want 11", lat); end
      bad = (rk_seq.size() != 11);
      for (int i = 0; i < rk_seq.size() && i < 11; i++) if (rk_seq[i] != 10 - i) bad = 1;
      checks++; if (bad) begin errors++; $display("FAIL fips_rk_seq got %p want 10..0", rk_seq); end
   endtask

   task automatic test_key_stall();
      logic [127:0] pt; int lat; bit tmo, bad;
      load_key(FIPS_KEY);
      drive_block(FIPS_CT, 1'b1, pt, lat, tmo);
      checks++; if (pt !== FIPS_PT) begin errors++; $display("FAIL stall_data got %h want %h", pt, FIPS_PT); end
      checks++; if (tmo || lat != 14) begin errors++; $display("FAIL stall_latency got %0d want 14", lat); end
      bad = (rk_seq.size() != 11);
      for (int i = 0; i < rk_seq.size() && i < 11; i++) if (rk_seq[i] != 10 - i) bad = 1;
      checks++; if (bad) begin errors++; $display("FAIL stall_rk_seq got %p want 10..0", rk_seq); end
   endtask

   task automatic test_key_invalid_idle();
      bit bad;
      bad = 0;
      @(negedge clk);
      key_valid = 1'b0; in_valid = 1'b1; in_data = FIPS_CT;
      repeat (5) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || rk_idx !== 4'd10 || out_valid !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL nokey_idle got in_ready=%b rk_idx=%0d want 0/10", in_ready, rk_idx); end
      in_valid = 1'b0; key_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nokey_no_accept got in_ready=%b want 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] cts [2];
      logic [127:0] outs [$];
      int acc [$];
      int low_cnt, idx;
      bit pending;
      load_key(FIPS_KEY);
      cts[0] = FIPS_CT;
      cts[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = 1'b1; low_cnt = 0; idx = 0;
      @(negedge clk);
      in_data = cts[0]; in_valid = 1'b1;
      for (int n = 0; n < 60 && outs.size() < 2; n++) begin
         pending = in_valid && in_ready;
         if (out_valid) begin
            outs.push_back(out_data);
            $display("b2b out=%h at cycle %0d", out_data, n);
         end
         if (pending) acc.push_back(n);
         else if (acc.size() == 1 && !in_ready) low_cnt++;
         @(posedge clk); #1;
         if (pending) begin
            idx++;
            if (idx < 2) in_data = cts[idx];
            else in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (acc.size() != 2 || acc[1] - acc[0] != 12) begin errors++; $display("FAIL b2b_period got %p want spacing 12", acc); end
      checks++; if (low_cnt != 11) begin errors++; $display("FAIL b2b_in_ready_low got %0d want 11", low_cnt); end
      checks++; if (outs.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", outs.size()); end
      else begin
         checks++; if (outs[0] !== FIPS_PT) begin errors++; $display("FAIL b2b_first got %h want %h", outs[0], FIPS_PT); end
         checks++; if (outs[1] !== ref_decrypt(cts[1])) begin errors++; $display("FAIL b2b_second got %h want %h", outs[1], ref_decrypt(cts[1])); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] pt, ct, snap; int lat; bit tmo, bad_v, bad_d, bad_r;
      ct = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = 1'b0;
      drive_block(ct, 1'b0, pt, lat, tmo);
      snap = out_data;
      bad_v = 0; bad_d = 0; bad_r = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b1) bad_v = 1;
         if (out_data !== snap) bad_d = 1;
         if (in_ready !== 1'b0) bad_r = 1;
      end
      checks++; if (tmo || pt !== ref_decrypt(ct)) begin errors++; $display("FAIL bp_data got %h want %h", pt, ref_decrypt(ct)); end
      checks++; if (bad_v) begin errors++; $display("FAIL bp_out_valid got %b want held 1", out_valid); end
      checks++; if (bad_d) begin errors++; $display("FAIL bp_out_data got %h want stable %h", out_data, snap); end
      checks++; if (bad_r) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_random();
      logic [127:0] key, ct, pt; int lat; bit tmo;
      for (int k = 0; k < 6; k++) begin
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
         load_key(key);
         out_ready = 1'b0;
         drive_block(ct, 1'b0, pt, lat, tmo);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         out_ready = 1'b1;
         checks++; if (tmo || pt !== ref_decrypt(ct)) begin errors++; $display("FAIL rand_data got %h want %h", pt, ref_decrypt(ct)); end
         checks++; if (lat != 11) begin errors++; $display("FAIL rand_latency got %0d want 11", lat); end
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_release got %b want 0", out_valid); end
      end
   endtask

   task automatic test_midblock_reset();
      logic [127:0] ct, pt; int n, lat; bit tmo, bad;
      load_key(FIPS_KEY);
      @(negedge clk);
      in_data = FIPS_CT; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      checks++; if (!in_ready) begin errors++; $display("FAIL rstmid_accept got in_ready=0 want 1"); end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL rstmid_rk_idx got %0d want 10", rk_idx); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== key_valid) begin errors++; $display("FAIL rstmid_in_ready got %b want %b", in_ready, key_valid); end
      bad = 0;
      repeat (15) begin @(negedge clk); if (out_valid !== 1'b0) bad = 1; end
      checks++; if (bad) begin errors++; $display("FAIL rstmid_spurious got out_valid=1 want 0"); end
      ct = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive_block(ct, 1'b0, pt, lat, tmo);
      checks++; if (tmo || pt !== ref_decrypt(ct)) begin errors++; $display("FAIL rstmid_next got %h want %h", pt, ref_decrypt(ct)); end
      checks++; if (lat != 11) begin errors++; $display("FAIL rstmid_latency got %0d want 11", lat); end
      @(negedge clk);
   endtask

`ifdef INV_CIPHER_BLKCNT_EN
   task automatic test_blkcnt();
      logic [127:0] pt; int lat; bit tmo;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (blk_cnt !== 32'd0) begin errors++; $display("FAIL blkcnt_reset got %0d want 0", blk_cnt); end
      rst_n = 1'b1; out_ready = 1'b1;
      load_key(FIPS_KEY);
      repeat (5) drive_block(FIPS_CT, 1'b0, pt, lat, tmo);
      @(negedge clk);
      checks++; if (blk_cnt !== 32'd5) begin errors++; $display("FAIL blkcnt_count got %0d want 5", blk_cnt); end
      rst_n = 1'b0;
      #1;
      checks++; if (blk_cnt !== 32'd0) begin errors++; $display("FAIL blkcnt_clear got %0d want 0", blk_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      key_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) rk_mem[i] = '0;
      build_tables();
      test_reset();
      test_fips();
      test_key_stall();
      test_key_invalid_idle();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_midblock_reset();
`ifdef INV_CIPHER_BLKCNT_EN
      test_blkcnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
